// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core's
// load/store port and an external (DMA/debug) requester.
// The CPU has default priority. The external port is guaranteed bandwidth in
// two ways: an anti-starvation wait counter, and a bounded locked burst.
// Optional build macro DMEM_ARB_STATS_EN adds stall and grant counters.
module dmem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic              ext_lock,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wd,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
  , output logic [15:0]     stall_cycles
  , output logic [15:0]     ext_grants
`endif
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, EXT_BURST} state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
  } mem_req_t;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               ext_rvalid_q;
  logic [DATA_W-1:0]  ext_rd_q;

  logic     starve, burst_ok, cpu_win, ext_win;
  mem_req_t req;

  assign starve   = (wait_q == WAIT_W'(MAX_WAIT));
  assign burst_ok = (state_q == EXT_BURST) && ext_req && (burst_q < BURST_W'(MAX_BURST));

  // Same-cycle grant: a live burst wins, otherwise the CPU unless ext is starved.
  always_comb begin
    cpu_win = !burst_ok && cpu_req && !(ext_req && starve);
    ext_win = !cpu_win && ext_req;
    req     = '0;
    if (cpu_win)      req = '{we: cpu_we, addr: cpu_addr, wd: cpu_wd};
    else if (ext_win) req = '{we: ext_we, addr: ext_addr, wd: ext_wd};
  end

  // Reset low gates the write strobe so an in-flight store is dropped.
  assign mem_we     = req.we & reset;
  assign mem_addr   = req.addr;
  assign mem_wd     = req.wd;
  assign cpu_rd     = cpu_win ? mem_rd : '0;
  assign cpu_stall  = cpu_req && !cpu_win;
  assign ext_gnt    = ext_win;
  assign ext_rvalid = ext_rvalid_q;
  assign ext_rd     = ext_rd_q;

  // Next state, burst length and starvation counter.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    wait_d  = '0;
    if (ext_req && !ext_win)
      wait_d = starve ? wait_q : wait_q + WAIT_W'(1);
    case (state_q)
      IDLE: begin
        if (ext_win && ext_lock) begin
          state_d = EXT_BURST;
          burst_d = BURST_W'(1);
        end
      end
      EXT_BURST: begin
        if (!ext_req) begin
          state_d = IDLE;
          burst_d = '0;
        end else if (!burst_ok) begin
          // Expired burst: this cycle was arbitrated as IDLE. If the CPU was
          // idle, ext won again and a locked grant starts a fresh burst.
          state_d = IDLE;
          burst_d = '0;
          if (ext_win && ext_lock) begin
            state_d = EXT_BURST;
            burst_d = BURST_W'(1);
          end
        end else if (!ext_lock) begin
          state_d = IDLE;
          burst_d = '0;
        end else begin
          burst_d = burst_q + BURST_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
    end
  end

  // One-cycle registered return path for external reads; data holds otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ext_rvalid_q <= 1'b0;
      ext_rd_q     <= '0;
    end else begin
      ext_rvalid_q <= ext_win && !ext_we;
      if (ext_win && !ext_we) ext_rd_q <= mem_rd;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_q, egnt_q;
  assign stall_cycles = stall_q;
  assign ext_grants   = egnt_q;

  // Saturating event counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      egnt_q  <= '0;
    end else begin
      if (cpu_stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (ext_win && egnt_q != 16'hFFFF)    egnt_q  <= egnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the single-cycle MIPS core's load/store port and an external requester (DMA/debug loader).
- Sits between the core's data-memory pins (alu_out/dmem_wd/dmem_we/rd) and dmem.
- CPU has default priority. An anti-starvation counter and a bounded burst lock give the external port guaranteed bandwidth.
- When the CPU loses arbitration it receives a stall so the core holds its PC.

Parameters:
ADDR_W, 10, word-address width driven to dmem.ra
DATA_W, 32, data width
MAX_WAIT, 4, consecutive denied ext cycles before ext is forced ahead of CPU (>=1)
MAX_BURST, 8, max consecutive locked ext grants before CPU must be served (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  core performs lw/sw this cycle
cpu_we  in  1  core store
cpu_addr  in  ADDR_W  core address
cpu_wd  in  DATA_W  core store data
cpu_rd  out  DATA_W  load data to core (combinational from mem_rd)
cpu_stall  out  1  core must hold PC/instruction this cycle
ext_req  in  1  external access request
ext_we  in  1  external write
ext_lock  in  1  request to keep ownership on following cycle
ext_addr  in  ADDR_W  external address
ext_wd  in  DATA_W  external write data
ext_gnt  out  1  ext access performed this cycle
ext_rvalid  out  1  registered: ext read data valid
ext_rd  out  DATA_W  registered ext read data
mem_we  out  1  to dmem.we
mem_addr  out  ADDR_W  to dmem.ra
mem_wd  out  DATA_W  to dmem.wd
mem_rd  in  DATA_W  from dmem.rd (combinational read)

Behaviour:
- FSM states: IDLE, EXT_BURST.
- Registers: wait_cnt (saturates at MAX_WAIT), burst_cnt (0..MAX_BURST).
- starve = (wait_cnt == MAX_WAIT).
- Grant (combinational, same cycle):
  - In EXT_BURST with ext_req=1 and burst_cnt < MAX_BURST: ext granted.
  - Else if cpu_req and !(ext_req && starve): cpu granted.
  - Else if ext_req: ext granted.
  - Else: no grant.
- Outputs follow grant:
  - ext_gnt = ext granted.
  - cpu_stall = cpu_req && !cpu granted.
  - mem_* muxed from the granted requester.
  - No grant: mem_we=0, mem_addr=0, mem_wd=0.
  - mem_we is never 1 without a grant.
- cpu_rd = mem_rd when cpu granted, else 0.
- wait_cnt: +1 (saturating) when ext_req && !ext_gnt; cleared when ext_gnt or !ext_req.
- Transitions:
  - IDLE -> EXT_BURST when ext_gnt && ext_lock; burst_cnt <= 1.
  - EXT_BURST, each further ext_gnt with ext_lock: burst_cnt+1.
  - EXT_BURST -> IDLE (burst_cnt <= 0) when any of:
    - ext_req=0
    - ext_lock=0 on a granted cycle
    - burst_cnt == MAX_BURST (the cycle is arbitrated as IDLE; CPU wins if requesting)
- After a burst expires, wait_cnt restarts from 0, so the CPU gets at least one slot if it is requesting.
- ext read: when ext_gnt && !ext_we, next edge sets ext_rvalid=1 and ext_rd=mem_rd; otherwise ext_rvalid=0 and ext_rd holds. Latency 1 cycle.
- ext write: committed at the edge of the grant cycle (dmem synchronous write).
- Simultaneous cpu_req and ext_req, IDLE, wait_cnt<MAX_WAIT: CPU wins.
- Reset (any time, including mid-burst): state=IDLE, wait_cnt=0, burst_cnt=0, ext_rvalid=0, ext_rd=0.
  - Combinational outputs follow from the cleared state.
  - A write in flight at reset assertion is dropped (mem_we forced 0 while reset low).

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stall_cycles (16 bit) and ext_grants (16 bit).
  - stall_cycles counts cycles with cpu_stall=1; ext_grants counts cycles with ext_gnt=1.
  - Both saturate at 16'hFFFF, cleared by reset, updated at clock edge.
- Undefined: ports and counters absent; arbitration identical.

Test Plan:
- Reset low, random inputs -> mem_we=0, ext_rvalid=0, ext_rd=0. Release reset with no requests -> ext_gnt=0, cpu_stall=0.
- cpu_req=1, cpu_we=1, addr=0x010, wd=0xDEADBEEF, ext idle -> mem_we=1, mem_addr=0x010, cpu_stall=0. Next cycle CPU read of 0x010 -> cpu_rd=0xDEADBEEF.
- cpu_req held 1 and ext_req held 1 (lock=0), MAX_WAIT=4:
  - cycles 0-3: CPU granted, ext_gnt=0.
  - cycle 4: ext_gnt=1, cpu_stall=1.
  - cycle 5: CPU granted again.
- ext read of addr 0x020 holding 0x12345678 -> ext_gnt=1 in cycle N; ext_rvalid=1 and ext_rd=0x12345678 in cycle N+1 only.
- ext_lock=1 burst, cpu_req=1, MAX_BURST=8 after forced entry -> 8 consecutive ext_gnt, then cpu granted one cycle (cpu_stall=0). Assert reset mid-burst -> state IDLE, next grant goes to CPU.
- With DMEM_ARB_STATS_EN, the scenario-3 run (cycles 0-5) -> stall_cycles=1, ext_grants=1.
